// File: rtl/clock_sync_multi_if.sv
// Pin-side and consumer-side signals of the bus clock / bus-response synchroniser.
// master = pins plus bus-cycle state machine, slave = the synchroniser itself.
interface clock_sync_multi_if #(
    parameter int NCH      = 4,
    parameter int DELAY_W  = 5,
    parameter int PERIOD_W = 8
);
    logic                MCCLK;
    logic [NCH-1:0]      BUS_IN;
    logic [DELAY_W-1:0]  DELAY;
    logic                MCCLK_RISING;
    logic                MCCLK_FALLING;
    logic [PERIOD_W-1:0] PERIOD;
    logic                CLK_LOST;
    logic [NCH-1:0]      BUS_LEVEL;
    logic [NCH-1:0]      BUS_ASSERT;
    logic [NCH-1:0]      BUS_DEASSERT;

    modport master (
        output MCCLK, BUS_IN, DELAY,
        input  MCCLK_RISING, MCCLK_FALLING, PERIOD, CLK_LOST,
               BUS_LEVEL, BUS_ASSERT, BUS_DEASSERT
    );

    modport slave (
        input  MCCLK, BUS_IN, DELAY,
        output MCCLK_RISING, MCCLK_FALLING, PERIOD, CLK_LOST,
               BUS_LEVEL, BUS_ASSERT, BUS_DEASSERT
    );
endinterface

// File: rtl/clock_sync_multi.sv
// Synchronises the 68000 bus clock and NCH active-low bus-response inputs into SYSCLK,
// with edge strobes, MCCLK period measurement, lost-clock watchdog and a tapped delay line.
module clock_sync_multi #(
    parameter int SYNC_STAGES = 3,
    parameter int NCH         = 4,
    parameter int DELAY_W     = 5,
    parameter int PERIOD_W    = 8,
    parameter int TIMEOUT     = 200
) (
    input  logic SYSCLK,
    input  logic nRESET,
    clock_sync_multi_if.slave sif
);
    localparam int DEPTH = 2**DELAY_W;
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
    localparam logic [PERIOD_W-1:0] CNT_THR = PERIOD_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] mc_sync_q, mc_sync_d;
    logic                   mc_hist_q;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [PERIOD_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic                   lost_q, lost_d;
    logic                   mc_last;

    logic [NCH-1:0] bus_sync_q [SYNC_STAGES];
    logic [NCH-1:0] dline_q    [DEPTH];
    logic [NCH-1:0] bus_hist_q;
    logic [NCH-1:0] tap;

    always_comb begin
        mc_sync_d = {mc_sync_q[SYNC_STAGES-2:0], sif.MCCLK};
        mc_last   = mc_sync_q[SYNC_STAGES-1];
        rise_d    = mc_last & ~mc_hist_q;
        fall_d    = ~mc_last & mc_hist_q;
        cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        cnt_d     = rise_d ? '0 : cnt_inc;
        period_d  = rise_d ? cnt_inc : period_q;
        // The registered strobe clears the flag, so it stays visible through the strobe cycle.
        lost_d    = lost_q;
        if (rise_q) begin
            lost_d = 1'b0;
        end else if (cnt_q == CNT_THR && !rise_d) begin
            lost_d = 1'b1;
        end
    end

    always_ff @(negedge SYSCLK) begin
        if (!nRESET) begin
            mc_sync_q <= '0;
            mc_hist_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            lost_q    <= 1'b0;
        end else begin
            mc_sync_q <= mc_sync_d;
            mc_hist_q <= mc_last;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            lost_q    <= lost_d;
        end
    end

    assign tap = dline_q[sif.DELAY];

    always_ff @(negedge SYSCLK) begin
        if (!nRESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) bus_sync_q[i] <= '1;
            for (int i = 0; i < DEPTH; i++)       dline_q[i]    <= '1;
            bus_hist_q <= '1;
        end else begin
            bus_sync_q[0] <= sif.BUS_IN;
            for (int i = 1; i < SYNC_STAGES; i++) bus_sync_q[i] <= bus_sync_q[i-1];
            dline_q[0] <= bus_sync_q[SYNC_STAGES-1];
            for (int i = 1; i < DEPTH; i++)       dline_q[i]    <= dline_q[i-1];
            bus_hist_q <= tap;
        end
    end

    // Bus strobes are decoded from the live tap so they line up with the BUS_LEVEL change.
    assign sif.BUS_LEVEL     = tap;
    assign sif.BUS_ASSERT    = bus_hist_q & ~tap;
    assign sif.BUS_DEASSERT  = ~bus_hist_q & tap;
    assign sif.MCCLK_RISING  = rise_q;
    assign sif.MCCLK_FALLING = fall_q;
    assign sif.PERIOD        = period_q;
    assign sif.CLK_LOST      = lost_q;
endmodule

// File: doc/clock_sync_multi.md
Name: clock_sync_multi

Overview:
- Parametrised successor to the single-channel MC clock/DTACK synchroniser.
- Synchronises the 68000 bus clock (MCCLK) into the SYSCLK domain, emits one-cycle rising/falling strobes, measures the MCCLK period and flags a lost bus clock.
- Synchronises NCH active-low bus-response inputs (DTACK, VPA, BERR, ...) through a shared delay line whose tap is set at run time, with per-channel assert/deassert strobes.
- Sits between the bus pins and the bus-cycle state machine.

Parameters:
SYNC_STAGES, 3, synchroniser flops for MCCLK and each BUS_IN bit (minimum 2)
NCH, 4, number of active-low bus-response input channels
DELAY_W, 5, width of DELAY; delay line depth is 2**DELAY_W stages
PERIOD_W, 8, width of the period counter and PERIOD output
TIMEOUT, 200, SYSCLK cycles without an MCCLK rising edge before CLK_LOST asserts (must be < 2**PERIOD_W)

Ports:
SYSCLK  in  1  system clock; all registers update on the falling edge of SYSCLK
nRESET  in  1  synchronous, active-low reset, sampled on the falling edge of SYSCLK
MCCLK  in  1  asynchronous 68000 bus clock
BUS_IN  in  NCH  asynchronous active-low bus-response inputs
DELAY  in  DELAY_W  delay-line tap select, 0..2**DELAY_W-1 extra cycles
MCCLK_RISING  out  1  one-cycle strobe on synchronised MCCLK 0->1
MCCLK_FALLING  out  1  one-cycle strobe on synchronised MCCLK 1->0
PERIOD  out  PERIOD_W  SYSCLK cycles between the last two MCCLK rising edges, saturating
CLK_LOST  out  1  high while no MCCLK rising edge has occurred for TIMEOUT cycles
BUS_LEVEL  out  NCH  delayed, synchronised level per channel (active-low, as on the pins)
BUS_ASSERT  out  NCH  one-cycle strobe per channel on delayed level 1->0
BUS_DEASSERT  out  NCH  one-cycle strobe per channel on delayed level 0->1

Behaviour:
- Reset (nRESET=0 at a SYSCLK falling edge):
  - All synchroniser and delay-line flops load 1 for BUS_IN and 0 for MCCLK.
  - BUS_LEVEL = all 1s; all strobes = 0.
  - PERIOD = 0; CLK_LOST = 0; internal period counter = 0.
  - Reset mid-operation aborts any pending strobe; no strobe is emitted in the first cycle after reset release.
- MCCLK path:
  - SYNC_STAGES-flop shift chain, plus one history flop behind the last stage.
  - MCCLK_RISING = 1 for exactly one cycle when last stage = 1 and history = 0. MCCLK_FALLING is the mirror case.
  - Strobes are registered. Latency from an MCCLK edge to its strobe is SYNC_STAGES+1 SYSCLK cycles (±1 for sampling uncertainty).
  - RISING and FALLING are never high in the same cycle.
- Period counter:
  - Increments every cycle and saturates at 2**PERIOD_W-1.
  - In the cycle MCCLK_RISING is generated: PERIOD loads the counter value + 1 (saturating) and the counter clears to 0.
  - The first rising edge after reset loads a value that is not a true period; the consumer ignores it.
- Watchdog:
  - CLK_LOST sets when the counter equals TIMEOUT-1 and no rising edge occurs in that cycle.
  - It stays high until the cycle after the next MCCLK_RISING, then clears.
  - A rising edge in the same cycle as the threshold wins: no set.
- BUS path:
  - Each BUS_IN bit passes through SYNC_STAGES flops, then a shared delay line of 2**DELAY_W stages, NCH bits wide.
  - BUS_LEVEL = delay stage[DELAY]; DELAY=0 selects the first stage after the synchroniser.
  - A per-channel history flop on the tapped value produces BUS_ASSERT (history=1, tap=0) and BUS_DEASSERT (history=0, tap=1), each one cycle long.
  - Latency from pin to BUS_LEVEL change = SYNC_STAGES+1+DELAY cycles; strobes coincide with the BUS_LEVEL change.
- DELAY changed at run time:
  - The tap switches immediately.
  - A resulting level change produces a normal strobe.
  - A pulse that is skipped over is lost; this is acceptable and the consumer changes DELAY only between bus cycles.
- Pulse filtering: an input pulse shorter than one SYSCLK period may be missed. A pulse that is sampled is reproduced with unchanged width at the tap.
- Channels are independent; simultaneous edges on several channels give simultaneous strobes.

Test Plan:
- Reset: hold nRESET=0 for 4 cycles with BUS_IN=0, MCCLK toggling -> all strobes 0, BUS_LEVEL=4'hF, PERIOD=0, CLK_LOST=0; first cycle after release also strobe-free.
- MCCLK at 1/16 of SYSCLK (8 high, 8 low), SYNC_STAGES=3 -> MCCLK_RISING every 16 cycles, 4 cycles after the edge; FALLING 8 cycles later; PERIOD=16 from the second rising edge.
- Stop MCCLK low after one rising edge -> CLK_LOST=1 exactly 200 cycles after that edge's strobe; restart MCCLK -> CLK_LOST=0 the cycle after the next MCCLK_RISING.
- DELAY=14, BUS_IN[0] (DTACK) driven low for 6 cycles -> BUS_ASSERT[0] 18 cycles after the falling input edge; BUS_DEASSERT[0] 6 cycles later; other channels silent.
- DELAY=0, BUS_IN=4'b0101 asserted simultaneously -> BUS_ASSERT=4'b1010 in one cycle, 4 cycles after input.
- Period saturation: MCCLK period 300 cycles with TIMEOUT=200 -> PERIOD=255 and CLK_LOST pulses high between edges.
